// File: rtl/key_bounce_gen_if.sv
// key_bounce_gen_if -- request/status bundle for the key bounce generator.
// master: the stimulus side that requests presses and watches the key.
// slave : the generator itself.
interface key_bounce_gen_if;
   logic start;
   logic abort;
   logic key_out;
   logic clean_key;
   logic busy;
   logic done;

   modport master (
      output start, abort,
      input  key_out, clean_key, busy, done
   );

   modport slave (
      input  start, abort,
      output key_out, clean_key, busy, done
   );
endinterface

// File: rtl/key_bounce_gen.sv
// key_bounce_gen -- produces one bouncy key press per start request:
// a noisy falling window, a stable low hold, a noisy rising window.
// Optional feature macro: KEY_BOUNCE_EN adds LFSR noise to key_out inside
// the bounce windows; without it key_out is simply the clean key level.
module key_bounce_gen #(
   parameter int         BOUNCE_CYC = 20,
   parameter int         HOLD_CYC   = 50,
   parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
   input  logic             clk,
   input  logic             rst,
   key_bounce_gen_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BNC_DN = 2'd1,
      HOLD   = 2'd2,
      BNC_UP = 2'd3
   } state_t;

   localparam int MAX_CYC = (BOUNCE_CYC > HOLD_CYC) ? BOUNCE_CYC : HOLD_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   // The counter holds "cycles left after this one", so the last cycle of a
   // phase is the one where it reads zero.
   localparam logic [CNT_W-1:0] BNC_LOAD  = CNT_W'(BOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             key_out_q, key_out_d;
   logic             clean_key_q, clean_key_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

`ifdef KEY_BOUNCE_EN
   logic [7:0]       lfsr_q, lfsr_d;
`endif

   // Next state, counter reload/decrement, and the registered outputs that
   // belong to the next state, so each output lines up with its state.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
      state_d     = state_q;
      cnt_d       = cnt_q;
`ifdef KEY_BOUNCE_EN
      lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif

      unique case (state_q)
         IDLE: begin
            // abort beats start when both arrive together
            if (bus.start && !bus.abort) begin
               state_d = BNC_DN;
               cnt_d   = BNC_LOAD;
            end
         end
         BNC_DN: begin
            if (bus.abort) begin
               state_d = BNC_UP;
               cnt_d   = BNC_LOAD;
            end else if (cnt_q == CNT_ZERO) begin
               state_d = HOLD;
               cnt_d   = HOLD_LOAD;
            end else begin
               cnt_d   = cnt_q - CNT_ONE;
            end
         end
         HOLD: begin
            if (bus.abort || cnt_q == CNT_ZERO) begin
               state_d = BNC_UP;
               cnt_d   = BNC_LOAD;
            end else begin
               cnt_d   = cnt_q - CNT_ONE;
            end
         end
         BNC_UP: begin
            // abort is deliberately ignored here; the release window finishes
            if (cnt_q == CNT_ZERO) begin
               state_d = IDLE;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d   = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase

      busy_d      = (state_d != IDLE);
      done_d      = (state_q == BNC_UP) && (state_d == IDLE);
      clean_key_d = (state_d == IDLE) || (state_d == BNC_UP);

`ifdef KEY_BOUNCE_EN
      // Noise during the windows, but each window ends on its settled level.
      unique case (state_d)
         BNC_DN:  key_out_d = (cnt_d == CNT_ZERO) ? 1'b0 : lfsr_d[0];
         HOLD:    key_out_d = 1'b0;
         BNC_UP:  key_out_d = (cnt_d == CNT_ZERO) ? 1'b1 : lfsr_d[0];
         default: key_out_d = 1'b1;
      endcase
`else
      key_out_d   = clean_key_d;
`endif
   end

   // State, counter, noise source and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= CNT_ZERO;
         key_out_q   <= 1'b1;
         clean_key_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef KEY_BOUNCE_EN
         lfsr_q      <= LFSR_SEED;
`endif
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values together.
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         key_out_q   <= key_out_d;
         clean_key_q <= clean_key_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef KEY_BOUNCE_EN
         lfsr_q      <= lfsr_d;
`endif
      end
   end

   assign bus.key_out   = key_out_q;
   assign bus.clean_key = clean_key_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
// tb_key_bounce_gen -- self-checking bench for key_bounce_gen.
// A press-timeline model (cycle index within the press plus the cycle at
// which the release window begins) predicts every output each cycle;
// directed scenarios pin the model with hand-computed cycle numbers.
module tb_key_bounce_gen;

   localparam int         B    = 20;
   localparam int         H    = 50;
   localparam logic [7:0] SEED = 8'hA5;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   key_bounce_gen_if intf ();

   key_bounce_gen #(
      .BOUNCE_CYC (B),
      .HOLD_CYC   (H),
      .LFSR_SEED  (SEED)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (intf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit         m_in_press;
   int         m_k;        // cycle number within the current press (1-based)
   int         m_up;       // cycle number at which the release window starts
   bit         m_done;
   logic [7:0] m_lfsr;

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   function automatic int exp_clean();
      if (!m_in_press) return 1;
      return (m_k >= m_up) ? 1 : 0;
   endfunction

   function automatic int exp_key();
`ifdef KEY_BOUNCE_EN
      if (!m_in_press)             return 1;
      if (m_k >= m_up)             return (m_k == m_up + B - 1) ? 1 : int'(m_lfsr[0]);
      if (m_k <= B)                return (m_k == B) ? 0 : int'(m_lfsr[0]);
      return 0;
`else
      return exp_clean();
`endif
   endfunction

   // Model advance on each edge, then compare all outputs shortly after it.
   always @(posedge clk) begin
      if (rst) begin
         m_in_press = 1'b0;
         m_k        = 0;
         m_up       = 0;
         m_done     = 1'b0;
         m_lfsr     = SEED;
      end else begin
         m_lfsr = lfsr_step(m_lfsr);
         if (!m_in_press) begin
            m_done = 1'b0;
            if (intf.start && !intf.abort) begin
               m_in_press = 1'b1;
               m_k        = 1;
               m_up       = B + H + 1;
            end
         end else begin
            if (intf.abort && m_k < m_up) m_up = m_k + 1;
            m_k++;
            if (m_k == m_up + B) begin
               m_in_press = 1'b0;
               m_done     = 1'b1;
            end
         end
      end
      #1;
      check("key_out",   int'(intf.key_out),   exp_key());
      check("clean_key", int'(intf.clean_key), exp_clean());
      check("busy",      int'(intf.busy),      m_in_press ? 1 : 0);
      check("done",      int'(intf.done),      m_done ? 1 : 0);
   end

   // ---------------- stimulus helpers ----------------
   // Apply inputs for one cycle and return just after the edge that samples them.
   task automatic drive_cycle(input bit s, input bit a);
      @(negedge clk);
      intf.start = s;
      intf.abort = a;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      int busy_cnt;
      int done_cnt;
      int done_cyc;
      int clean_rise;
      int falls;
      int rises;
      int fall_cyc;
      int rise_cyc;
      int key20;
      int key90;
      int low_20_70;
   } press_stats_t;

   // Issue a start, then watch cycles 1..n, with an optional extra start or
   // abort in a chosen cycle.
   task automatic observe(input int n, input int start_at, input int abort_at,
                          output press_stats_t st);
      logic prev_key, prev_clean;
      st = '{default: 0};
      st.done_cyc   = -1;
      st.clean_rise = -1;
      prev_key      = 1'b1;
      prev_clean    = 1'b1;
      drive_cycle(1'b1, 1'b0);
      for (int c = 1; c <= n; c++) begin
         if (intf.busy) st.busy_cnt++;
         if (intf.done) begin
            st.done_cnt++;
            if (st.done_cyc < 0) st.done_cyc = c;
         end
         if (intf.clean_key && !prev_clean && st.clean_rise < 0) st.clean_rise = c;
         if (!intf.key_out && prev_key) begin st.falls++; st.fall_cyc = c; end
         if (intf.key_out && !prev_key) begin st.rises++; st.rise_cyc = c; end
         if (c == 20) st.key20 = int'(intf.key_out);
         if (c == 90) st.key90 = int'(intf.key_out);
         if (c >= 20 && c <= 70 && !intf.key_out) st.low_20_70++;
         prev_key   = intf.key_out;
         prev_clean = intf.clean_key;
         drive_cycle(c == start_at, c == abort_at);
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      press_stats_t st;
      checks     = 0;
      errors     = 0;
      rst        = 1'b1;
      intf.start = 1'b0;
      intf.abort = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_key_out",   int'(intf.key_out),   1);
      check("rst_clean_key", int'(intf.clean_key), 1);
      check("rst_busy",      int'(intf.busy),      0);
      check("rst_done",      int'(intf.done),      0);
      rst = 1'b0;
      repeat (2) drive_cycle(1'b0, 1'b0);

      // Plain press with default timing.
      observe(100, 0, 0, st);
      check("press_busy_cycles", st.busy_cnt,   90);
      check("press_done_cycle",  st.done_cyc,   91);
      check("press_done_count",  st.done_cnt,   1);
      check("press_key_c20",     st.key20,      0);
      check("press_key_c90",     st.key90,      1);
      check("press_low_20_70",   st.low_20_70,  51);
      check("press_clean_rise",  st.clean_rise, 71);
`ifndef KEY_BOUNCE_EN
      check("clean_falls",    st.falls,    1);
      check("clean_rises",    st.rises,    1);
      check("clean_fall_cyc", st.fall_cyc, 1);
      check("clean_rise_cyc", st.rise_cyc, 71);
`endif

      // A second start mid-press is ignored.
      observe(100, 30, 0, st);
      check("restart_done_count", st.done_cnt, 1);
      check("restart_done_cycle", st.done_cyc, 91);
      check("restart_busy",       st.busy_cnt, 90);

      // Abort during HOLD jumps straight to the release window.
      observe(100, 0, 40, st);
      check("abort_clean_rise", st.clean_rise, 41);
      check("abort_done_cycle", st.done_cyc,   61);
      check("abort_busy",       st.busy_cnt,   60);

      // Abort during the release window changes nothing.
      observe(100, 0, 80, st);
      check("late_abort_done", st.done_cyc, 91);

      // start and abort together in IDLE: stay idle.
      drive_cycle(1'b1, 1'b1);
      check("start_abort_busy", int'(intf.busy),    0);
      check("start_abort_key",  int'(intf.key_out), 1);
      drive_cycle(1'b0, 1'b0);
      check("start_abort_busy2", int'(intf.busy), 0);

      // Reset mid-press: outputs return to idle at once, press is abandoned.
      drive_cycle(1'b1, 1'b0);
      repeat (34) drive_cycle(1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("midrst_key_out",   int'(intf.key_out),   1);
      check("midrst_clean_key", int'(intf.clean_key), 1);
      check("midrst_busy",      int'(intf.busy),      0);
      check("midrst_done",      int'(intf.done),      0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      observe(100, 0, 0, st);
      check("postrst_busy",      st.busy_cnt, 90);
      check("postrst_done_cyc",  st.done_cyc, 91);

      // Randomised traffic, including occasional resets.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 999) == 0) begin
            @(negedge clk);
            rst        = 1'b1;
            intf.start = 1'b0;
            intf.abort = 1'b0;
            @(negedge clk);
            rst = 1'b0;
         end else begin
            drive_cycle($urandom_range(0, 15) == 0, $urandom_range(0, 79) == 0);
         end
      end
      drive_cycle(1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
